// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_ACK,
    WAIT_IDLE
  } ps2_state_t;

  // Falling edges of the device clock: 11 frame bits, then the acknowledge edge.
  localparam logic [3:0] FRAME_FALLS = 4'd11;
  localparam logic [3:0] ACK_FALL    = 4'd12;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Frame bit i is the level the host presents after clock fall i: start, D0..D7, P, stop.
  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-stage synchronizer for an asynchronous PS/2 pin plus a one-cycle falling-edge pulse.
module ps2_line_sync (
  input  logic Clock25,
  input  logic Reset,
  input  logic line,
  output logic synced,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so the chain resets to 1 to avoid a spurious edge.
  always_ff @(posedge Clock25) begin
    // NOTE: non-blocking assignments let each stage capture its predecessor's old value, forming a real shift chain.
    if (!Reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign synced = sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out 11 bits
// on device clock falls, then collect the acknowledge; every output is registered.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       Clock25,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] DataI,
  output logic       Busy,
  output logic       Done,
  output logic       AckErr,
  output logic       Timeout,
  input  logic       ClockT_in,
  input  logic       DataT_in,
  output logic       ClockT_oe,
  output logic       DataT_oe
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state, state_d;
  logic [INH_W-1:0] inh_cnt, inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic [3:0]       edge_cnt, edge_cnt_d, edge_nxt;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             busy_d, done_d, ack_err_d, timeout_d, clk_oe_d, data_oe_d;

  logic        clk_sync, clk_fall, data_sync, data_fall_unused;
  logic [10:0] frame;
  logic        counting, line_idle, tmo_expire, abort;

  ps2_line_sync u_clk_sync (
    .Clock25 (Clock25),
    .Reset   (Reset),
    .line    (ClockT_in),
    .synced  (clk_sync),
    .fall    (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .Clock25 (Clock25),
    .Reset   (Reset),
    .line    (DataT_in),
    .synced  (data_sync),
    .fall    (data_fall_unused)
  );

  assign frame      = build_frame(data_q, parity_q);
  assign edge_nxt   = edge_cnt + 4'd1;
  assign counting   = state inside {REQ, SEND, WAIT_ACK, WAIT_IDLE};
  assign line_idle  = clk_sync & data_sync;
  assign tmo_expire = (tmo_cnt == TMO_LAST);
  // A completion seen on the terminal cycle takes priority over the abort.
  assign abort      = counting && tmo_expire && !(state == WAIT_IDLE && line_idle);

  always_ff @(posedge Clock25) begin
    if (!Reset) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      edge_cnt  <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      AckErr    <= 1'b0;
      Timeout   <= 1'b0;
      ClockT_oe <= 1'b0;
      DataT_oe  <= 1'b0;
    end else begin
      state     <= state_d;
      inh_cnt   <= inh_cnt_d;
      tmo_cnt   <= tmo_cnt_d;
      edge_cnt  <= edge_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      Busy      <= busy_d;
      Done      <= done_d;
      AckErr    <= ack_err_d;
      Timeout   <= timeout_d;
      ClockT_oe <= clk_oe_d;
      DataT_oe  <= data_oe_d;
    end
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps every path assigned, so no latch is inferred.
    state_d = state;
    unique case (state)
      IDLE:      if (Start) state_d = INHIBIT;
      INHIBIT:   if (inh_cnt == INH_LAST) state_d = REQ;
      REQ:       if (clk_fall) state_d = SEND;
      SEND:      if (clk_fall && edge_nxt == FRAME_FALLS) state_d = WAIT_ACK;
      WAIT_ACK:  if (clk_fall && edge_nxt == ACK_FALL) state_d = WAIT_IDLE;
      WAIT_IDLE: if (line_idle) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    inh_cnt_d  = inh_cnt;
    tmo_cnt_d  = counting ? tmo_cnt + TMO_W'(1) : tmo_cnt;
    edge_cnt_d = edge_cnt;
    data_d     = data_q;
    parity_d   = parity_q;
    busy_d     = Busy;
    done_d     = 1'b0;
    ack_err_d  = AckErr;
    timeout_d  = 1'b0;
    clk_oe_d   = ClockT_oe;
    data_oe_d  = DataT_oe;

    unique case (state)
      IDLE: begin
        if (Start) begin
          data_d    = DataI;
          parity_d  = odd_parity(DataI);
          inh_cnt_d = '0;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt + INH_W'(1);
        if (inh_cnt == INH_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b1;
          tmo_cnt_d  = '0;
          edge_cnt_d = '0;
        end else if (inh_cnt + INH_W'(1) == INH_LAST) begin
          // Data goes low during the final inhibit cycle so the start bit is already up at release.
          data_oe_d = 1'b1;
        end
      end
      REQ, SEND: begin
        if (clk_fall) begin
          edge_cnt_d = edge_nxt;
          if (edge_nxt < FRAME_FALLS) data_oe_d = ~frame[edge_nxt];
        end
      end
      WAIT_ACK: begin
        if (clk_fall) begin
          edge_cnt_d = edge_nxt;
          ack_err_d  = data_sync;
        end
      end
      WAIT_IDLE: begin
        if (line_idle) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (abort) begin
      timeout_d = 1'b1;
      busy_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the DUT and
// compares them, plus ack/timeout/reset outcomes, against a byte-level frame model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 4000;
  localparam int HALF = 20;

  logic       Clock25 = 1'b0;
  logic       Reset   = 1'b0;
  logic       Start   = 1'b0;
  logic [7:0] DataI   = '0;
  logic       Busy, Done, AckErr, Timeout, ClockT_oe, DataT_oe;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_pin, data_pin;

  assign clk_pin  = ~(ClockT_oe | dev_clk_low);
  assign data_pin = ~(DataT_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock25   (Clock25),
    .Reset     (Reset),
    .Start     (Start),
    .DataI     (DataI),
    .Busy      (Busy),
    .Done      (Done),
    .AckErr    (AckErr),
    .Timeout   (Timeout),
    .ClockT_in (clk_pin),
    .DataT_in  (data_pin),
    .ClockT_oe (ClockT_oe),
    .DataT_oe  (DataT_oe)
  );

  always #20 Clock25 = ~Clock25;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  // Pulse and inhibit-window monitor, sampling the values held during each cycle.
  int done_count = 0, tmo_count = 0, inh_runs = 0, inh_len = 0, inh_data_pos = 0;
  int run = 0, data_pos = 0;

  always @(posedge Clock25) begin
    if (Done === 1'b1) done_count <= done_count + 1;
    if (Timeout === 1'b1) tmo_count <= tmo_count + 1;
    if (ClockT_oe === 1'b1) begin
      run <= run + 1;
      if (DataT_oe === 1'b1 && data_pos == 0) data_pos <= run + 1;
    end else if (run != 0) begin
      inh_len      <= run;
      inh_data_pos <= data_pos;
      inh_runs     <= inh_runs + 1;
      run          <= 0;
      data_pos     <= 0;
    end
  end

  int snap_done, snap_tmo, snap_inh;

  task automatic start_cmd(input logic [7:0] b);
    snap_done = done_count;
    snap_tmo  = tmo_count;
    snap_inh  = inh_runs;
    Start = 1'b1;
    DataI = b;
    @(negedge Clock25);
    Start = 1'b0;
    DataI = 8'($urandom);
    check("busy_after_start", Busy, 1);
  endtask

  // Device: waits for request-to-send, samples data before each clock fall, then acks.
  task automatic device_frame(input bit ack, input int abort_fall, input logic [7:0] b,
                              output logic [10:0] got, output bit ok);
    int n;
    logic [10:0] fr;
    logic e;
    fr  = exp_frame(b);
    got = '0;
    n   = 0;
    while (!(clk_pin === 1'b1 && data_pin === 1'b0) && n < 200) begin
      @(negedge Clock25);
      n++;
    end
    ok = (n < 200);
    if (!ok) return;
    repeat (10) @(negedge Clock25);
    for (int f = 1; f <= 11; f++) begin
      repeat (HALF) @(negedge Clock25);
      got[f-1] = data_pin;
      dev_clk_low = 1'b1;
      if (f == abort_fall) begin
        repeat (10) @(negedge Clock25);
        e = ~fr[f];
        check("abort_pre_data_oe", DataT_oe, e);
        Reset = 1'b0;
        @(negedge Clock25);
        check("abort_clk_oe", ClockT_oe, 0);
        check("abort_data_oe", DataT_oe, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        Reset = 1'b1;
        dev_clk_low = 1'b0;
        return;
      end
      repeat (HALF) @(negedge Clock25);
      dev_clk_low = 1'b0;
    end
    dev_data_low = ack;
    repeat (HALF) @(negedge Clock25);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge Clock25);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic finish_check(input string tag, input logic [7:0] b, input logic [10:0] got,
                              input bit ok, input bit nack);
    int n;
    n = 0;
    check({tag, ":req_seen"}, ok, 1);
    check({tag, ":frame"}, got, exp_frame(b));
    check({tag, ":inhibit_runs"}, inh_runs, snap_inh + 1);
    check({tag, ":inhibit_len"}, inh_len, INH);
    check({tag, ":inhibit_data_pos"}, inh_data_pos, INH);
    while (Done !== 1'b1 && n < 200) begin
      @(negedge Clock25);
      n++;
    end
    check({tag, ":done"}, Done, 1);
    check({tag, ":ack_err"}, AckErr, nack);
    check({tag, ":clk_oe_released"}, ClockT_oe, 0);
    check({tag, ":data_oe_released"}, DataT_oe, 0);
    @(negedge Clock25);
    check({tag, ":busy_after_done"}, Busy, 0);
    check({tag, ":done_one_cycle"}, Done, 0);
    check({tag, ":done_count"}, done_count, snap_done + 1);
    check({tag, ":no_timeout"}, tmo_count, snap_tmo);
  endtask

  initial begin
    repeat (60000) @(posedge Clock25);
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] got;
    bit          ok;
    int          n;
    logic [7:0]  t2 [3];
    logic [7:0]  rb;

    t2[0] = 8'h01;
    t2[1] = CMD_RESET;
    t2[2] = 8'h00;

    Reset = 1'b0;
    repeat (3) @(negedge Clock25);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_ack_err", AckErr, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_clk_oe", ClockT_oe, 0);
    check("rst_data_oe", DataT_oe, 0);
    Reset = 1'b1;
    repeat (5) @(negedge Clock25);

    // Set-LEDs command with acknowledge; also compared against a literal frame.
    start_cmd(CMD_SET_LEDS);
    device_frame(1'b1, 0, CMD_SET_LEDS, got, ok);
    check("t1:literal_frame", got, 11'b1_1_11101101_0);
    finish_check("t1_ed", CMD_SET_LEDS, got, ok, 1'b0);

    // Parity corners and a few random bytes.
    for (int i = 0; i < 6; i++) begin
      rb = (i < 3) ? t2[i] : 8'($urandom);
      repeat (10) @(negedge Clock25);
      start_cmd(rb);
      device_frame(1'b1, 0, rb, got, ok);
      finish_check($sformatf("t2_%02h", rb), rb, got, ok, 1'b0);
    end

    // Device withholds the acknowledge.
    repeat (10) @(negedge Clock25);
    start_cmd(8'hA5);
    device_frame(1'b0, 0, 8'hA5, got, ok);
    finish_check("t3_nack", 8'hA5, got, ok, 1'b1);

    // Device never clocks: abort exactly TMO cycles after clock release.
    repeat (10) @(negedge Clock25);
    start_cmd(8'h3C);
    n = 0;
    while (ClockT_oe !== 1'b0 && n < 100) begin
      @(negedge Clock25);
      n++;
    end
    check("t4:clk_released", ClockT_oe, 0);
    check("t4:start_bit_driven", DataT_oe, 1);
    n = 0;
    while (Timeout !== 1'b1 && n < TMO + 100) begin
      @(negedge Clock25);
      n++;
    end
    check("t4:timeout_latency", n, TMO);
    check("t4:clk_oe", ClockT_oe, 0);
    check("t4:data_oe", DataT_oe, 0);
    check("t4:busy", Busy, 0);
    check("t4:done_low", Done, 0);
    @(negedge Clock25);
    check("t4:timeout_one_cycle", Timeout, 0);
    check("t4:timeout_count", tmo_count, snap_tmo + 1);
    check("t4:no_done", done_count, snap_done);

    // Reset in the middle of a frame, then a normal echo command.
    repeat (10) @(negedge Clock25);
    start_cmd(8'h00);
    device_frame(1'b1, 5, 8'h00, got, ok);
    check("t5:req_seen", ok, 1);
    repeat (100) @(negedge Clock25);
    check("t5:no_done", done_count, snap_done);
    check("t5:idle_busy", Busy, 0);
    start_cmd(CMD_ECHO);
    device_frame(1'b1, 0, CMD_ECHO, got, ok);
    finish_check("t5_echo", CMD_ECHO, got, ok, 1'b0);

    // Start pulses while busy must not disturb the frame in flight.
    repeat (10) @(negedge Clock25);
    start_cmd(8'h96);
    fork
      device_frame(1'b1, 0, 8'h96, got, ok);
      begin
        repeat (5) @(negedge Clock25);
        Start = 1'b1;
        DataI = 8'h69;
        @(negedge Clock25);
        Start = 1'b0;
        repeat (200) @(negedge Clock25);
        Start = 1'b1;
        DataI = 8'h55;
        @(negedge Clock25);
        Start = 1'b0;
      end
    join
    finish_check("t6_busy_start", 8'h96, got, ok, 1'b0);
    repeat (100) @(negedge Clock25);
    check("t6:single_done", done_count, snap_done + 1);
    check("t6:stays_idle", Busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same two open-drain lines that the keyboard receiver listens on. It runs entirely on the system clock and oversamples the device-generated PS/2 clock. Busy is exported so the top level can gate the receiver while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 2500, Clock25 cycles the PS/2 clock is held low before the request (100 us at 25 MHz).
TIMEOUT_CYCLES, 375000, maximum Clock25 cycles from clock release to ack/idle (15 ms); exceeding it aborts the transfer.

Ports:
Clock25  in  1  system clock, 25 MHz, rising edge.
Reset  in  1  synchronous, active-low reset: when 0 at a Clock25 rising edge, the block resets.
Start  in  1  request; sampled only in IDLE.
DataI  in  8  command byte; latched on an accepted Start.
Busy  out  1  high from the cycle after an accepted Start until Done/Timeout.
Done  out  1  one-cycle pulse at successful or failed completion.
AckErr  out  1  valid with Done; 1 = device did not acknowledge (DataT_in high at ack edge).
Timeout  out  1  one-cycle pulse on abort.
ClockT_in  in  1  PS/2 clock pin level (asynchronous).
DataT_in  in  1  PS/2 data pin level (asynchronous).
ClockT_oe  out  1  1 = drive PS/2 clock low, 0 = release.
DataT_oe  out  1  1 = drive PS/2 data low, 0 = release.

Behaviour:
- All outputs are registered. Reset values: Busy=0, Done=0, AckErr=0, Timeout=0, ClockT_oe=0, DataT_oe=0. State=IDLE.
- Reset mid-transfer releases both lines on the next edge. No Done is produced.
- Pin inputs pass through a 2-FF synchronizer. fall = previous synced clock is 1 and current synced clock is 0, one cycle wide.
- Frame: odd parity bit P = ~^DataI. Shift order is start(0), D0..D7 (LSB first), P, stop (released = 1).
- IDLE:
  - Start=1 latches DataI and computes P; go to INHIBIT.
  - Start while not in IDLE is ignored.
- INHIBIT:
  - ClockT_oe=1 for INHIBIT_CYCLES cycles.
  - On the last of those cycles DataT_oe is also set to 1.
  - Then go to REQ.
- REQ:
  - ClockT_oe=0, DataT_oe=1 (start bit); clear the timeout counter and the edge counter.
  - Wait for fall #1; go to SEND.
- SEND: on fall #k, present the bit for fall k+1 in the same cycle as the fall pulse.
  - k=1..8: DataT_oe = ~D[k-1].
  - k=9: DataT_oe = ~P.
  - k=10: DataT_oe=0 (stop).
  - After fall #11, go to WAIT_ACK.
- WAIT_ACK: on fall #12 sample synced DataT_in. 0 sets AckErr=0, 1 sets AckErr=1. Go to WAIT_IDLE.
- WAIT_IDLE: when synced clock and data are both 1, pulse Done for one cycle, drop Busy, go to IDLE.
- Timeout:
  - The counter runs in REQ, SEND, WAIT_ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse Timeout, drop Busy, go to IDLE. No Done.
  - If the terminal count coincides with a completion condition, completion wins.
- Latency from pin falling edge to DataT_oe update: 3 Clock25 cycles (2 sync stages + registered output).
- A new Start may be accepted in the cycle after Done or Timeout.
- Edge counter is 4 bits; the timeout counter width is ceil(log2(TIMEOUT_CYCLES+1)).

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE);
  - frame constants FRAME_FALLS=11, ACK_FALL=12;
  - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ECHO=8'hEE.
  - The keyboard receiver shares this package.
- One sub-module, ps2_line_sync: 2-FF synchronizer plus falling-edge pulse. Instantiate it on the clock line; on the data line, use its synced output only.

Test Plan:
Bench settings: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=4000; device model clocks at 40 Clock25 cycles per PS/2 period.
1. Start with DataI=8'hED, device acks -> ClockT_oe high exactly 20 cycles; bits the device samples = 0,1,0,1,1,0,1,1,1, parity 1, stop 1; Done=1 with AckErr=0; Busy low the cycle after Done.
2. DataI=8'h01 -> device samples parity 0; DataI=8'hFF -> parity 1; DataI=8'h00 -> parity 1. All complete with AckErr=0.
3. Device holds data high at fall #12 -> Done=1 with AckErr=1, lines released, state IDLE.
4. Device never clocks after REQ -> Timeout pulses 4000 cycles after clock release; ClockT_oe=0 and DataT_oe=0; Done never asserted.
5. Reset driven 0 after fall #5 -> next cycle both oe=0, Busy=0, no Done. A following Start with 8'hEE completes normally.
6. Start pulsed again while Busy -> ignored; the first byte is transmitted unchanged and exactly one Done is produced.
